// File: rtl/wide_add_seq_pkg.sv
// wide_add_seq shared types and helpers.
// FSM states, byte width and ID width helper.
package wide_add_seq_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wide_add_seq_rca.sv
// wide_add_seq 8-bit ripple-carry adder slice.
// One byte of the wide sum per clock.
module wide_add_seq_rca
  import wide_add_seq_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] sum,
  output logic              cout
);

  // Bit-by-bit ripple of the carry
  always_comb begin
    logic cy;
    sum = '0;
    cy  = cin;
    for (int i = 0; i < BYTE_W; i++) begin
      sum[i] = a[i] ^ b[i] ^ cy;
      cy     = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
    end
    cout = cy;
  end

endmodule

// File: rtl/wide_add_seq.sv
// wide_add_seq: byte-serial wide adder, round-robin shared.
// Define WIDE_ADD_SEQ_SUB_EN to add req_sub (A - B).
module wide_add_seq
  import wide_add_seq_pkg::*;
#(
  parameter  int NBYTES = 4,
  parameter  int NREQ   = 2,
  localparam int W      = 8 * NBYTES,
  localparam int IW     = id_w(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_opa,
  input  logic [NREQ*W-1:0] req_opb,
  input  logic [NREQ-1:0]   req_cin,
`ifdef WIDE_ADD_SEQ_SUB_EN
  input  logic [NREQ-1:0]   req_sub,
`endif
  output logic              res_valid,
  input  logic              res_ready,
  output logic [W-1:0]      res_data,
  output logic              res_cout,
  output logic [IW-1:0]     res_id
);

  localparam int IXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IXW-1:0] LAST = IXW'(NBYTES - 1);
  localparam logic [IW-1:0]  RMAX = IW'(NREQ - 1);

  state_t            state;
  state_t            state_nx;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     gnt;
  logic              gnt_ok;
  logic              accept;
  logic [IXW-1:0]    idx;
  logic              carry;
  logic [W-1:0]      opa;
  logic [W-1:0]      opb;
  logic              sub_q;
  logic              sub_in;
  logic [BYTE_W-1:0] a_byte;
  logic [BYTE_W-1:0] b_byte;
  logic [BYTE_W-1:0] s_byte;
  logic              c_byte;

`ifdef WIDE_ADD_SEQ_SUB_EN
  assign sub_in = req_sub[gnt];
`else
  assign sub_in = 1'b0;
`endif

  // First valid requester at or above rr_ptr, wrapping
  always_comb begin
    int p;
    gnt    = '0;
    gnt_ok = 1'b0;
    p      = 0;
    for (int j = 0; j < NREQ; j++) begin
      p = int'(rr_ptr) + j;
      if (p >= NREQ) p = p - NREQ;
      if (!gnt_ok && req_valid[p]) begin
        gnt    = IW'(p);
        gnt_ok = 1'b1;
      end
    end
  end

  assign accept = (state == IDLE) && gnt_ok && rst_n;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state and grant strobe
  always_comb begin
    state_nx  = state;
    req_ready = '0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          req_ready[gnt] = 1'b1;
          state_nx       = RUN;
        end
      end
      RUN: begin
        if (idx == LAST) state_nx = DONE;
      end
      DONE: begin
        if (res_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign a_byte = opa[idx*BYTE_W +: BYTE_W];
  assign b_byte = opb[idx*BYTE_W +: BYTE_W]
                ^ {BYTE_W{sub_q}};

  wide_add_seq_rca u_rca (
    .a    (a_byte),
    .b    (b_byte),
    .cin  (carry),
    .sum  (s_byte),
    .cout (c_byte)
  );

  // Operand latch, byte sequencing and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      idx       <= '0;
      carry     <= 1'b0;
      opa       <= '0;
      opb       <= '0;
      sub_q     <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_cout  <= 1'b0;
      res_id    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            opa    <= req_opa[gnt*W +: W];
            opb    <= req_opb[gnt*W +: W];
            sub_q  <= sub_in;
            carry  <= sub_in | req_cin[gnt];
            res_id <= gnt;
            rr_ptr <= (gnt == RMAX) ? '0 : gnt + 1'b1;
            idx    <= '0;
          end
        end
        RUN: begin
          res_data[idx*BYTE_W +: BYTE_W] <= s_byte;
          carry <= c_byte;
          if (idx == LAST) begin
            idx       <= '0;
            res_valid <= 1'b1;
            res_cout  <= c_byte;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (res_ready) res_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wide_add_seq.sv
// tb_wide_add_seq: directed checks for wide_add_seq.
// NBYTES=4, NREQ=2; sub cases when WIDE_ADD_SEQ_SUB_EN.
module tb_wide_add_seq;

  localparam int NB = 4;
  localparam int NR = 2;
  localparam int W  = 8 * NB;

  logic            clk;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*W-1:0] req_opa;
  logic [NR*W-1:0] req_opb;
  logic [NR-1:0]   req_cin;
  logic [NR-1:0]   req_sub;
  logic            res_valid;
  logic            res_ready;
  logic [W-1:0]    res_data;
  logic            res_cout;
  logic [0:0]      res_id;

  int tests;
  int fails;

  wide_add_seq #(.NBYTES(NB), .NREQ(NR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_opa   (req_opa),
    .req_opb   (req_opb),
    .req_cin   (req_cin),
`ifdef WIDE_ADD_SEQ_SUB_EN
    .req_sub   (req_sub),
`endif
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_cout  (res_cout),
    .res_id    (res_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic c);
    req_opa[i*W +: W] = a;
    req_opb[i*W +: W] = b;
    req_cin[i]        = c;
  endtask

  task automatic issue(input string tag, input int i);
    req_valid[i] = 1'b1;
    #1;
    chk({tag, "_ready"}, 64'(req_ready), 64'(1 << i));
    tick();
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_result(input string tag,
                             input logic [W-1:0] d,
                             input logic c,
                             input logic id,
                             input int hold);
    for (int n = 1; n <= NB; n++) begin
      if (n == NB) chk({tag, "_early"}, 64'(res_valid), 0);
      tick();
    end
    chk({tag, "_valid"}, 64'(res_valid), 1);
    chk({tag, "_data"}, 64'(res_data), 64'(d));
    chk({tag, "_cout"}, 64'(res_cout), 64'(c));
    chk({tag, "_id"}, 64'(res_id), 64'(id));
    for (int h = 0; h < hold; h++) begin
      tick();
      chk({tag, "_hv"}, 64'(res_valid), 1);
      chk({tag, "_hd"}, 64'(res_data), 64'(d));
      chk({tag, "_hc"}, 64'(res_cout), 64'(c));
      chk({tag, "_hi"}, 64'(res_id), 64'(id));
      chk({tag, "_hr"}, 64'(req_ready), 0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, "_drop"}, 64'(res_valid), 0);
    chk({tag, "_keep"}, 64'(res_data), 64'(d));
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    req_valid = 2'b01;
    req_opa   = '0;
    req_opb   = '0;
    req_cin   = '0;
    req_sub   = '0;
    res_ready = 1'b0;
    repeat (2) tick();
    chk("rst_valid", 64'(res_valid), 0);
    chk("rst_data", 64'(res_data), 0);
    chk("rst_cout", 64'(res_cout), 0);
    chk("rst_id", 64'(res_id), 0);
    chk("rst_ready", 64'(req_ready), 0);
    req_valid = '0;
    rst_n     = 1'b1;
    tick();

    set_op(0, 32'h0000_00FF, 32'h0000_0001, 1'b0);
    issue("t1", 0);
    wait_result("t1", 32'h0000_0100, 1'b0, 1'b0, 0);

    set_op(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    issue("t2", 1);
    wait_result("t2", 32'h0000_0000, 1'b1, 1'b1, 0);

    set_op(0, 32'h1234_5678, 32'h1111_1111, 1'b1);
    issue("t3", 0);
    wait_result("t3", 32'h2345_678A, 1'b0, 1'b0, 0);

    set_op(1, 32'h0101_0101, 32'h0202_0202, 1'b0);
    issue("ab", 1);
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    chk("ab_valid", 64'(res_valid), 0);
    chk("ab_data", 64'(res_data), 0);
    chk("ab_cout", 64'(res_cout), 0);
    chk("ab_id", 64'(res_id), 0);
    chk("ab_ready", 64'(req_ready), 0);
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      tick();
      chk("ab_stale", 64'(res_valid), 0);
    end

    set_op(0, 32'h0000_0001, 32'h0000_0001, 1'b0);
    set_op(1, 32'h0000_0010, 32'h0000_0020, 1'b0);
    req_valid = 2'b11;
    #1;
    chk("rr1_g0", 64'(req_ready), 64'(2'b01));
    tick();
    req_valid[0] = 1'b0;
    wait_result("rr1_a", 32'h0000_0002, 1'b0, 1'b0, 3);
    chk("rr1_g1", 64'(req_ready), 64'(2'b10));
    tick();
    req_valid[1] = 1'b0;
    wait_result("rr1_b", 32'h0000_0030, 1'b0, 1'b1, 0);

    set_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    issue("t4", 0);
    wait_result("t4", 32'hFFFF_FFFF, 1'b1, 1'b0, 0);

    set_op(0, 32'h0000_000A, 32'h0000_0005, 1'b0);
    set_op(1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    req_valid = 2'b11;
    #1;
    chk("rr2_g1", 64'(req_ready), 64'(2'b10));
    tick();
    req_valid[1] = 1'b0;
    wait_result("rr2_b", 32'h0000_0000, 1'b1, 1'b1, 0);
    chk("rr2_g0", 64'(req_ready), 64'(2'b01));
    tick();
    req_valid[0] = 1'b0;
    wait_result("rr2_a", 32'h0000_000F, 1'b0, 1'b0, 0);

`ifdef WIDE_ADD_SEQ_SUB_EN
    req_sub = 2'b01;
    set_op(0, 32'h0000_0005, 32'h0000_0007, 1'b0);
    issue("s1", 0);
    wait_result("s1", 32'hFFFF_FFFE, 1'b0, 1'b0, 0);
    set_op(0, 32'h0000_0007, 32'h0000_0005, 1'b0);
    issue("s2", 0);
    wait_result("s2", 32'h0000_0002, 1'b1, 1'b0, 0);
    req_sub = 2'b00;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
